// File: rtl/regfile_wb_sink.sv
// MIPS general-purpose register file fed by the writeback stage: byte-granular commit,
// two combinational read ports with write-to-read bypass. Define REGFILE_TRACE_EN for the commit trace.
module regfile_wb_sink #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   wb_pc,
  input  logic [3:0]    wb_regwrite,
  input  logic [4:0]    wb_writereg,
  input  logic [DW-1:0] wb_result,
  input  logic [4:0]    raddr1,
  input  logic [4:0]    raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  output logic [31:0]   debug_wb_pc,
  output logic [3:0]    debug_wb_rf_wen,
  output logic [4:0]    debug_wb_rf_wnum,
  output logic [DW-1:0] debug_wb_rf_wdata,
  output logic [31:0]   debug_commit_cnt
);

  logic [DW-1:0] regs [1:NREG-1];
  logic          wr_valid;

  assign wr_valid = (wb_writereg != '0) && (int'(wb_writereg) < NREG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NREG; r++) regs[r] <= '0;
    end else if (wr_valid) begin
      for (int b = 0; b < 4; b++)
        if (wb_regwrite[b]) regs[wb_writereg][8*b +: 8] <= wb_result[8*b +: 8];
    end
  end

  // Bypass presents the value the register will hold after the current edge.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (!rst) begin
      if (raddr1 != '0 && int'(raddr1) < NREG) rdata1 = regs[raddr1];
      if (raddr2 != '0 && int'(raddr2) < NREG) rdata2 = regs[raddr2];
      if (wr_valid) begin
        for (int b = 0; b < 4; b++) begin
          if (wb_regwrite[b] && raddr1 == wb_writereg) rdata1[8*b +: 8] = wb_result[8*b +: 8];
          if (wb_regwrite[b] && raddr2 == wb_writereg) rdata2[8*b +: 8] = wb_result[8*b +: 8];
        end
      end
    end
  end

`ifdef REGFILE_TRACE_EN
  logic [31:0] commit_cnt;
  logic [3:0]  trace_wen;

  assign trace_wen         = (rst || wb_writereg == '0) ? 4'b0000 : wb_regwrite;
  assign debug_wb_pc       = rst ? '0 : wb_pc;
  assign debug_wb_rf_wen   = trace_wen;
  assign debug_wb_rf_wnum  = rst ? '0 : wb_writereg;
  assign debug_wb_rf_wdata = rst ? '0 : wb_result;
  assign debug_commit_cnt  = commit_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             commit_cnt <= '0;
    else if (|trace_wen) commit_cnt <= commit_cnt + 32'd1;
  end
`else
  logic unused_trace;

  assign unused_trace      = ^wb_pc;
  assign debug_wb_pc       = '0;
  assign debug_wb_rf_wen   = '0;
  assign debug_wb_rf_wnum  = '0;
  assign debug_wb_rf_wdata = '0;
  assign debug_commit_cnt  = '0;
`endif

endmodule

// File: doc/regfile_wb_sink.md
Name: regfile_wb_sink

Overview:
- Architectural MIPS general-purpose register file. It is the receiving end of the writeback stage's register-write interface: pc, 4-bit byte regwrite, writereg and result.
- Commits writeback results with byte granularity.
- Serves two decode-stage read ports, with same-cycle write-to-read bypass.
- Optionally emits the CQU/Loongson-style commit trace with a commit counter.

Parameters:
- NREG, 32, number of architectural registers (register 0 hardwired to zero)
- DW, 32, data width in bits; must equal 4 × 8

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- wb_pc  input  32  PC of the instruction in writeback
- wb_regwrite  input  4  per-byte write enable; bit i covers result[8i+7:8i]
- wb_writereg  input  5  destination register index
- wb_result  input  32  writeback data
- raddr1  input  5  read port 1 index
- raddr2  input  5  read port 2 index
- rdata1  output  32  read port 1 data
- rdata2  output  32  read port 2 data
- debug_wb_pc  output  32  commit trace PC (feature only)
- debug_wb_rf_wen  output  4  commit trace byte enables (feature only)
- debug_wb_rf_wnum  output  5  commit trace register (feature only)
- debug_wb_rf_wdata  output  32  commit trace data (feature only)
- debug_commit_cnt  output  32  count of committed writes (feature only)

Behaviour:
- Storage: registers 1..31, 32 bits each. Register 0 is not stored; reads of index 0 always return 0.
- Reset (async, rst=1): all registers clear to 0 immediately, without waiting for clk.
  - rdata1/rdata2 follow combinationally, so they read 0 for every index during reset.
  - Trace outputs read 0 and debug_commit_cnt = 0 during reset.
  - Writes presented while rst=1 are discarded.
- Write: on rising clk with rst=0, for each i where wb_regwrite[i]=1 and wb_writereg≠0, reg[wb_writereg][8i+7:8i] ← wb_result[8i+7:8i].
  - Bytes with enable 0 keep their value.
  - Writes to index 0 are ignored entirely.
- Read: combinational, zero-cycle latency.
- Bypass, per port: if raddrN = wb_writereg ≠ 0, each byte i is taken from wb_result when wb_regwrite[i]=1, otherwise from storage. Reads therefore see the value that will exist after the current edge.
- Both ports may address the same register and may both bypass in the same cycle; both return identical data.
- wb_regwrite = 4'b0000: no state change and no bypass, whatever wb_writereg and wb_result hold.
- Mid-operation reset: a write in flight at reset assertion is lost. After deassertion, the first rising edge accepts writes normally.
- No back-pressure: every enabled write on every edge is committed. The writeback stage must not present a write it intends to cancel.

Optional Feature:
- Macro: REGFILE_TRACE_EN.
- Defined:
  - debug_wb_pc = wb_pc, debug_wb_rf_wen = wb_regwrite, debug_wb_rf_wnum = wb_writereg, debug_wb_rf_wdata = wb_result, all combinational.
  - debug_wb_rf_wen is forced to 0 when wb_writereg = 0 or rst = 1.
  - debug_commit_cnt increments by 1 on each rising edge where the forced debug_wb_rf_wen ≠ 0. It wraps from 0xFFFFFFFF to 0.
- Undefined: all five debug outputs are tied to 0 and no counter flop is synthesised. The ports remain present so the top level is unchanged.

Test Plan:
- Reset check: write reg5 = 0x12345678, then assert rst asynchronously mid-cycle → rdata1 (raddr1=5) reads 0x00000000 before the next clk edge; debug_commit_cnt = 0.
- Full and byte writes: write reg3 = 0xAABBCCDD with en 4'b1111, then write 0x11223344 with en 4'b0101 → after the edge, reg3 reads 0xAA22CC44.
- Register zero: write 0xFFFFFFFF to reg0 with en 4'b1111 → raddr1=0 reads 0; with the feature on, debug_wb_rf_wen = 0 and the count is unchanged.
- Bypass: reg7 = 0x01020304; in the same cycle, write 0xA0B0C0D0 with en 4'b1100 and read raddr1 = raddr2 = 7 → both ports read 0xA0B00304 before the edge and after it.
- Idle write: en 4'b0000, writereg=9, result 0xDEADBEEF → reg9 is unchanged and no bypass occurs; the count is unchanged.
- Counter (feature on): 3 enabled writes to nonzero registers interleaved with 2 idle cycles → debug_commit_cnt = 3. Preload the counter to 0xFFFFFFFF via forced stimulus, then do one write → counter reads 0.
